main_memory_model: RTL and testbench

Backing-store stage directly below the L2 cache in `cache_system_2level`. It services L2 refill reads and write-backs over a valid/ready request channel and a valid/ready response channel. It models a fixed multi-cycle memory latency and allows one outstanding transaction. After reset it self-initialises every word to its own address, so miss-path data is predictable without preloading.

---
 rtl/main_memory_model.sv | 160 ++++++++++++++++
 tb/tb_main_memory_model.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/main_memory_model.sv
// Backing store below the L2 cache: fixed-latency, single-outstanding memory that self-initialises mem[i] = i.
// Optional access counters are built when MAIN_MEM_ACCESS_COUNT_EN is defined; otherwise rd_count/wr_count are tied to 0.
module main_memory_model #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 11,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_write,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  init_done,
   output logic [15:0]           rd_count,
   output logic [15:0]           wr_count
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   generate
      if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
         $error("main_memory_model: LATENCY must be in 1..15");
      end
   endgenerate

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_RESP} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_init_addr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_write;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_resp_data;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [3:0]            r_lat_cnt;
   logic                  r_init_done;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_waddr;
   logic [DATA_WIDTH-1:0] w_mem_wdata;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic                  w_resp_fire;

   assign req_ready   = (r_state == S_IDLE);
   assign resp_valid  = (r_state == S_RESP);
   assign resp_data   = r_resp_data;
   assign init_done   = r_init_done;
   assign w_resp_fire = (r_state == S_RESP) && resp_ready;

   // In IDLE the RAM is addressed by the incoming request so data is ready even when LATENCY is 1.
   assign w_rd_addr = (r_state == S_IDLE) ? req_addr : r_addr;

   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_waddr = r_addr;
      w_mem_wdata = r_wdata;
      case (r_state)
         S_INIT: begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_init_addr;
            w_mem_wdata = DATA_WIDTH'(r_init_addr);
         end
         S_RESP: begin
            w_mem_we = resp_ready && r_write;
         end
         default: begin
            w_mem_we = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdata;
      end
      r_rd_data <= r_mem[w_rd_addr];
   end

   // LATENCY = 1 still passes through BUSY with a zero count, so resp_valid lands LATENCY edges after acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_INIT;
         r_init_addr <= '0;
         r_addr      <= '0;
         r_write     <= 1'b0;
         r_wdata     <= '0;
         r_resp_data <= '0;
         r_lat_cnt   <= '0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            S_INIT: begin
               r_init_addr <= r_init_addr + 1'b1;
               if (&r_init_addr) begin
                  r_state     <= S_IDLE;
                  r_init_done <= 1'b1;
               end
            end
            S_IDLE: begin
               if (req_valid) begin
                  r_addr    <= req_addr;
                  r_write   <= req_write;
                  r_wdata   <= req_wdata;
                  r_lat_cnt <= 4'(LATENCY - 1);
                  r_state   <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_lat_cnt == 4'd0) begin
                  r_resp_data <= r_write ? r_wdata : r_rd_data;
                  r_state     <= S_RESP;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_INIT;
            end
         endcase
      end
   end

`ifdef MAIN_MEM_ACCESS_COUNT_EN
   logic [15:0] r_rd_count;
   logic [15:0] r_wr_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else if (w_resp_fire) begin
         if (r_write) begin
            if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
         end else begin
            if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
         end
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`else
   logic w_unused;
   assign w_unused = w_resp_fire;
   assign rd_count = 16'd0;
   assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_main_memory_model.sv
// Directed bench for main_memory_model at default parameters; expected response data flows through a scoreboard queue.
`timescale 1ns/1ps
module tb_main_memory_model;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [10:0] req_addr;
   logic        req_write;
   logic [10:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [10:0] resp_data;
   logic        init_done;
   logic [15:0] rd_count;
   logic [15:0] wr_count;

   int compared   = 0;
   int mismatched = 0;
   logic [10:0] sb_q[$];

   main_memory_model dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_write  (req_write),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .init_done  (init_done),
      .rd_count   (rd_count),
      .wr_count   (wr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits for init after rst release (called at a negedge with rst just dropped).
   task automatic wait_init(input string tag);
      int   cyc = 0;
      logic early = 1'b0;
      while (!init_done && cyc < 3000) begin
         if (req_ready) early = 1'b1;
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_cycles"}, cyc, 2048);
      chk({tag, "_early_ready"}, {31'd0, early}, 0);
      chk({tag, "_ready"}, {31'd0, req_ready}, 1);
      $display("init %s: init_done after %0d cycles", tag, cyc);
   endtask

   // One request; stall = cycles resp_ready is held low after resp_valid rises.
   task automatic txn(input string tag, input logic wr, input logic [10:0] addr,
                      input logic [10:0] wdata, input logic [10:0] exp, input int stall);
      int lat = 0;
      logic [10:0] want;
      sb_q.push_back(exp);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_addr   = addr;
      req_wdata  = wdata;
      resp_ready = (stall == 0);
      @(negedge clk);
      req_valid = 1'b0;
      while (!resp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, 4);
      want = sb_q.pop_front();
      for (int i = 0; i <= stall; i++) begin
         chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 1);
         chk({tag, "_resp_data"}, {21'd0, resp_data}, {21'd0, want});
         chk({tag, "_busy_ready"}, {31'd0, req_ready}, 0);
         if (i < stall) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 11'h123;
            req_wdata = 11'h7AA;
         end else begin
            req_valid  = 1'b0;
            resp_ready = 1'b1;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk({tag, "_valid_drop"}, {31'd0, resp_valid}, 0);
      chk({tag, "_ready_back"}, {31'd0, req_ready}, 1);
      $display("txn %s: %s addr=0x%03h data=0x%03h exp=0x%03h lat=%0d stall=%0d",
               tag, wr ? "WR" : "RD", addr, resp_data, want, lat, stall);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_write  = 1'b0;
      req_wdata  = '0;
      resp_ready = 1'b0;
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 0);
      chk("rst_init_done", {31'd0, init_done}, 0);
      chk("rst_resp_data", {21'd0, resp_data}, 0);
      chk("rst_rd_count", {16'd0, rd_count}, 0);
      chk("rst_wr_count", {16'd0, wr_count}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_init("init");

      txn("rd_123", 1'b0, 11'h123, 11'h000, 11'h123, 0);
      txn("wr_2a3", 1'b1, 11'h2A3, 11'h055, 11'h055, 0);
      txn("rd_2a3", 1'b0, 11'h2A3, 11'h000, 11'h055, 0);
      txn("rd_345", 1'b0, 11'h345, 11'h000, 11'h345, 0);
      txn("bp_123", 1'b0, 11'h123, 11'h000, 11'h123, 3);
      txn("rd_2a3b", 1'b0, 11'h2A3, 11'h000, 11'h055, 0);

      // Reset two cycles into BUSY: the write must never commit.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 11'h2A3;
      req_wdata = 11'h0AA;
      resp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("midbusy_in_busy", {31'd0, req_ready}, 0);
      rst = 1'b1;
      #1;
      chk("midbusy_resp_valid", {31'd0, resp_valid}, 0);
      chk("midbusy_req_ready", {31'd0, req_ready}, 0);
      chk("midbusy_init_done", {31'd0, init_done}, 0);
      chk("midbusy_rd_count", {16'd0, rd_count}, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_init("reinit");

      txn("rd_2a3_reinit", 1'b0, 11'h2A3, 11'h000, 11'h2A3, 0);
      txn("rd_7ff", 1'b0, 11'h7FF, 11'h000, 11'h7FF, 0);
      txn("wr_000", 1'b1, 11'h000, 11'h3C3, 11'h3C3, 0);
      txn("rd_000", 1'b0, 11'h000, 11'h000, 11'h3C3, 1);

`ifdef MAIN_MEM_ACCESS_COUNT_EN
      chk("rd_count", {16'd0, rd_count}, 3);
      chk("wr_count", {16'd0, wr_count}, 1);
`else
      chk("rd_count", {16'd0, rd_count}, 0);
      chk("wr_count", {16'd0, wr_count}, 0);
`endif
      $display("counters: rd=%0d wr=%0d", rd_count, wr_count);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
